pipe_hazard_unit: RTL and testbench
===================================

Name: pipe_hazard_unit

Overview:
Parametrised forwarding and hazard controller for the pipelined core. It replaces the fixed 3-source forwarding unit with NSTAGE forwarding sources and configurable load latency. It includes the operand data muxes and a counted load-use stall FSM that tolerates memory wait states. It also provides branch-flush gating and a stall statistics counter. It sits in ID, driving PC/IF_ID load enables, the CU bubble mux, and the Rn/Rm operand paths.

Parameters:
DW, 32, operand data width
RAW, 4, register address width
NSTAGE, 3, forwarding sources; index 0 = youngest (EX), NSTAGE-1 = oldest (WB)
LOAD_LAT, 2, stage index at which load data first becomes forwardable (sources with index < LOAD_LAT cannot forward a load)
PC_REG, 15, register address never forwarded (reads PC from the register file)
CW, 16, stall statistics counter width

Ports:
clk  in  1  clock, rising edge
R  in  1  reset, asynchronous, active-low
id_rn, id_rm  in  RAW each  ID source register addresses
id_rn_used, id_rm_used  in  1 each  operand actually read by the ID instruction
src_rd  in  NSTAGE*RAW  destination register per source, flat, source i at [i*RAW +: RAW]
src_we  in  NSTAGE  RF write enable per source
src_load  in  NSTAGE  source holds a load instruction
src_data  in  NSTAGE*DW  forwardable value per source
rf_pa, rf_pb  in  DW each  register file read ports
mem_wait  in  1  memory not ready; whole pipeline frozen
flush  in  1  branch taken, resolved in ID
fwd_a, fwd_b  out  DW each  forwarded Rn/Rm operands
sel_a, sel_b  out  SW each  SW=$clog2(NSTAGE+1); 0 = RF, i+1 = source i
pc_le, ifid_le  out  1 each  PC / IF_ID load enables
bubble  out  1  force CU mux to NOP into ID_EX
ifid_flush  out  1  clear IF_ID
stalling  out  1  FSM in STALL
stall_cnt  out  CW  saturating count of stall cycles

Behaviour:
- Reset (R=0, asynchronous): state IDLE, counter 0, stall_cnt 0. Outputs then follow IDLE: pc_le=ifid_le=1, bubble=0, stalling=0.
- Match for operand X (Rn or Rm): src_we[i] && src_rd[i]==id_rX && id_rX_used && id_rX!=PC_REG.
  - The lowest matching i wins.
  - sel=i+1 and fwd=src_data[i]; otherwise sel=0 and fwd=rf_pX. Combinational.
- Hazard: the winning source i for either operand has src_load[i]=1 and i<LOAD_LAT.
  - need = LOAD_LAT-i; take the max over both operands.
- FSM IDLE:
  - hazard && !mem_wait → load cnt=need-1 and assert stall in the same cycle. Go to STALL if need>1, else stay in IDLE.
- FSM STALL:
  - stall asserted; cnt decrements each cycle with !mem_wait.
  - Return to IDLE when cnt==0 and !mem_wait.
  - Hazard recompute is ignored while in STALL.
- Stall outputs: pc_le=0, ifid_le=0, bubble=1, stalling=(state==STALL).
- mem_wait=1: pc_le=ifid_le=0 and bubble=0 (freeze, not bubble). FSM and counter hold.
- ifid_flush = flush & ~stall & ~mem_wait. Flush is ignored during a stall; the CH re-evaluates once the branch completes ID.
- stall_cnt increments on every cycle with bubble=1 and saturates at 2^CW-1.
- Reset mid-stall returns to IDLE immediately with counters cleared.
- Simultaneous Rn and Rm hazards are serviced in one stall of length max(need).

Decomposition:
- Shared package hazard_pkg: the sel encoding constants (SEL_RF=0), the FSM state typedef {IDLE, STALL}, and PC_REG default.
- One natural sub-module: fwd_select (combinational priority match plus data mux), instantiated twice for Rn and Rm. The FSM and counters stay in pipe_hazard_unit.

Test Plan:
1. No match: id_rn=3, all src_we=0, rf_pa=0x11 → sel_a=0, fwd_a=0x11, pc_le=1, bubble=0.
2. Priority: src_rd={WB:5, MEM:5, EX:5}, all we=1, src_data EX=0xAA, id_rn=5 → sel_a=1, fwd_a=0xAA. With EX we=0 → sel_a=2.
3. Load-use at defaults: EX load writes R2, id_rm=2 → bubble=1, pc_le=0 for exactly 2 cycles, stalling=1 in the second. Load in MEM (i=1) → 1 stall cycle. stall_cnt=3 after both.
4. mem_wait=1 asserted for 3 cycles during the first STALL cycle → bubble=0 and freeze for those 3 cycles, then the remaining stall cycle. Total bubbles = 2.
5. id_rn=15 with EX writing R15 → sel_a=0. flush=1 with no stall → ifid_flush=1. flush=1 during a stall → ifid_flush=0.
6. R asserted low asynchronously mid-STALL → stalling=0, pc_le=1, stall_cnt=0 before the next clk edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller: operand-select code for the
// register file, default PC register index, and the stall FSM state type.
package hazard_pkg;
    localparam int SEL_RF         = 0;
    localparam int PC_REG_DEFAULT = 15;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_e;
endpackage

// File: rtl/fwd_select.sv
// Priority forwarding match and operand mux for one ID source operand.
// The youngest (lowest-index) writing source with a matching rd wins.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int DW     = 32,
    parameter int RAW    = 4,
    parameter int NSTAGE = 3,
    parameter int PC_REG = PC_REG_DEFAULT,
    parameter int SW     = $clog2(NSTAGE + 1)
) (
    input  logic [RAW-1:0]        id_r_i,
    input  logic                  id_used_i,
    input  logic [NSTAGE*RAW-1:0] src_rd_i,
    input  logic [NSTAGE-1:0]     src_we_i,
    input  logic [NSTAGE*DW-1:0]  src_data_i,
    input  logic [DW-1:0]         rf_data_i,
    output logic [SW-1:0]         sel_o,
    output logic [DW-1:0]         fwd_o
);
    always_comb begin
        sel_o = SW'(SEL_RF);
        fwd_o = rf_data_i;
        // Walk oldest to youngest so the youngest match overwrites the rest.
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (id_used_i && (id_r_i != RAW'(PC_REG)) && src_we_i[i] &&
                (src_rd_i[i*RAW +: RAW] == id_r_i)) begin
                sel_o = SW'(i + 1);
                fwd_o = src_data_i[i*DW +: DW];
            end
        end
    end
endmodule

// File: rtl/pipe_hazard_unit.sv
// ID-stage forwarding and load-use hazard controller: operand muxes, counted
// stall FSM that freezes under memory wait states, flush gating, stall stats.
module pipe_hazard_unit
    import hazard_pkg::*;
#(
    parameter int DW       = 32,
    parameter int RAW      = 4,
    parameter int NSTAGE   = 3,
    parameter int LOAD_LAT = 2,
    parameter int PC_REG   = PC_REG_DEFAULT,
    parameter int CW       = 16,
    localparam int SW      = $clog2(NSTAGE + 1)
) (
    input  logic                  clk,
    input  logic                  R,
    input  logic [RAW-1:0]        id_rn,
    input  logic [RAW-1:0]        id_rm,
    input  logic                  id_rn_used,
    input  logic                  id_rm_used,
    input  logic [NSTAGE*RAW-1:0] src_rd,
    input  logic [NSTAGE-1:0]     src_we,
    input  logic [NSTAGE-1:0]     src_load,
    input  logic [NSTAGE*DW-1:0]  src_data,
    input  logic [DW-1:0]         rf_pa,
    input  logic [DW-1:0]         rf_pb,
    input  logic                  mem_wait,
    input  logic                  flush,
    output logic [DW-1:0]         fwd_a,
    output logic [DW-1:0]         fwd_b,
    output logic [SW-1:0]         sel_a,
    output logic [SW-1:0]         sel_b,
    output logic                  pc_le,
    output logic                  ifid_le,
    output logic                  bubble,
    output logic                  ifid_flush,
    output logic                  stalling,
    output logic [CW-1:0]         stall_cnt
);
    localparam int CNTW = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;

    fwd_select #(.DW(DW), .RAW(RAW), .NSTAGE(NSTAGE), .PC_REG(PC_REG), .SW(SW)) u_fwd_rn (
        .id_r_i     (id_rn),
        .id_used_i  (id_rn_used),
        .src_rd_i   (src_rd),
        .src_we_i   (src_we),
        .src_data_i (src_data),
        .rf_data_i  (rf_pa),
        .sel_o      (sel_a),
        .fwd_o      (fwd_a)
    );

    fwd_select #(.DW(DW), .RAW(RAW), .NSTAGE(NSTAGE), .PC_REG(PC_REG), .SW(SW)) u_fwd_rm (
        .id_r_i     (id_rm),
        .id_used_i  (id_rm_used),
        .src_rd_i   (src_rd),
        .src_we_i   (src_we),
        .src_data_i (src_data),
        .rf_data_i  (rf_pb),
        .sel_o      (sel_b),
        .fwd_o      (fwd_b)
    );

    // Sources at or past LOAD_LAT never stall, so their load flags go unread.
    logic unused_load;
    assign unused_load = ^src_load;

    logic [CNTW-1:0] need_a, need_b, need;
    logic            hazard;

    always_comb begin
        need_a = '0;
        need_b = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            if ((i < LOAD_LAT) && src_load[i]) begin
                if (sel_a == SW'(i + 1)) need_a = CNTW'(LOAD_LAT - i);
                if (sel_b == SW'(i + 1)) need_b = CNTW'(LOAD_LAT - i);
            end
        end
        need   = (need_a > need_b) ? need_a : need_b;
        hazard = (need != '0);
    end

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CW-1:0]   stall_cnt_q, stall_cnt_d;
    logic            stall;

    // cnt holds the stall cycles still owed after the current one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (R && hazard && !mem_wait) begin
                    stall = 1'b1;
                    cnt_d = need - CNTW'(1);
                    if (need > CNTW'(1)) state_d = STALL;
                end
            end
            STALL: begin
                stall = 1'b1;
                if (!mem_wait) begin
                    cnt_d = cnt_q - CNTW'(1);
                    if (cnt_q == CNTW'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pc_le      = ~(stall | mem_wait);
    assign ifid_le    = ~(stall | mem_wait);
    assign bubble     = stall & ~mem_wait;
    assign ifid_flush = flush & ~stall & ~mem_wait;
    assign stalling   = (state_q == STALL);
    assign stall_cnt  = stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bubble && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: forwarding vector table, directed stall/freeze/
// flush/reset sequences, and random traffic against a cycle-level model.
module tb_pipe_hazard_unit;
    localparam int DW = 32, RAW = 4, NSTAGE = 3, LOAD_LAT = 2, CW = 16, SW = 2;

    logic                  clk = 1'b0;
    logic                  R;
    logic [RAW-1:0]        id_rn, id_rm;
    logic                  id_rn_used, id_rm_used;
    logic [NSTAGE*RAW-1:0] src_rd;
    logic [NSTAGE-1:0]     src_we, src_load;
    logic [NSTAGE*DW-1:0]  src_data;
    logic [DW-1:0]         rf_pa, rf_pb;
    logic                  mem_wait, flush;
    logic [DW-1:0]         fwd_a, fwd_b;
    logic [SW-1:0]         sel_a, sel_b;
    logic                  pc_le, ifid_le, bubble, ifid_flush, stalling;
    logic [CW-1:0]         stall_cnt;

    pipe_hazard_unit dut (
        .clk(clk), .R(R), .id_rn(id_rn), .id_rm(id_rm),
        .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
        .src_rd(src_rd), .src_we(src_we), .src_load(src_load), .src_data(src_data),
        .rf_pa(rf_pa), .rf_pb(rf_pb), .mem_wait(mem_wait), .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .sel_a(sel_a), .sel_b(sel_b),
        .pc_le(pc_le), .ifid_le(ifid_le), .bubble(bubble), .ifid_flush(ifid_flush),
        .stalling(stalling), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0, bubbles_seen = 0;
    int m_rem = 0;   // stall cycles still owed after the current cycle
    int m_cnt = 0;   // expected stall statistics counter

    typedef struct {
        logic [3:0]  rn, rm;
        logic        rn_u, rm_u;
        logic [11:0] rd;
        logic [2:0]  we;
        logic        fl;
        logic [1:0]  esa, esb;
        logic [31:0] efa, efb;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int ref_sel(input logic [RAW-1:0] r, input logic used);
        for (int i = 0; i < NSTAGE; i++)
            if (used && r != 4'd15 && src_we[i] && src_rd[i*RAW +: RAW] == r) return i + 1;
        return 0;
    endfunction

    function automatic logic [DW-1:0] ref_fwd(input int s, input logic [DW-1:0] rf);
        if (s == 0) return rf;
        return src_data[(s-1)*DW +: DW];
    endfunction

    function automatic int ref_need(input int s);
        if (s > 0 && src_load[s-1] && (s - 1) < LOAD_LAT) return LOAD_LAT - (s - 1);
        return 0;
    endfunction

    task automatic clear_inputs();
        id_rn = '0; id_rm = '0; id_rn_used = 1'b0; id_rm_used = 1'b0;
        src_rd = '0; src_we = '0; src_load = '0;
        src_data = {32'hCC, 32'hBB, 32'hAA};
        rf_pa = 32'h11; rf_pb = 32'h22;
        mem_wait = 1'b0; flush = 1'b0;
    endtask

    task automatic set_src(input int i, input logic [3:0] rd, input logic we, input logic ld);
        src_rd[i*RAW +: RAW] = rd;
        src_we[i] = we;
        src_load[i] = ld;
    endtask

    // Called just after a falling edge; checks outputs, then advances one clock.
    task automatic do_cycle(input string tag);
        int sa, sb, nd;
        logic stall_e;
        #1;
        sa = ref_sel(id_rn, id_rn_used);
        sb = ref_sel(id_rm, id_rm_used);
        nd = (ref_need(sa) > ref_need(sb)) ? ref_need(sa) : ref_need(sb);
        stall_e = R && (m_rem > 0 || (nd > 0 && !mem_wait));
        check({tag, ".sel_a"}, sel_a, sa);
        check({tag, ".sel_b"}, sel_b, sb);
        check({tag, ".fwd_a"}, fwd_a, ref_fwd(sa, rf_pa));
        check({tag, ".fwd_b"}, fwd_b, ref_fwd(sb, rf_pb));
        check({tag, ".pc_le"}, pc_le, !(stall_e || mem_wait));
        check({tag, ".ifid_le"}, ifid_le, !(stall_e || mem_wait));
        check({tag, ".bubble"}, bubble, stall_e && !mem_wait);
        check({tag, ".ifid_flush"}, ifid_flush, flush && !stall_e && !mem_wait);
        check({tag, ".stalling"}, stalling, m_rem > 0);
        check({tag, ".stall_cnt"}, stall_cnt, m_cnt);
        if (bubble) bubbles_seen++;
        @(posedge clk);
        if (R) begin
            if (stall_e && !mem_wait && m_cnt < 65535) m_cnt++;
            if (m_rem > 0) begin
                if (!mem_wait) m_rem--;
            end else if (nd > 0 && !mem_wait) begin
                m_rem = nd - 1;
            end
        end else begin
            m_rem = 0;
            m_cnt = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        R = 1'b0;
        clear_inputs();
        #1;
        check({tag, ".rst_stalling"}, stalling, 0);
        check({tag, ".rst_stall_cnt"}, stall_cnt, 0);
        check({tag, ".rst_pc_le"}, pc_le, 1);
        check({tag, ".rst_bubble"}, bubble, 0);
        @(negedge clk);
        R = 1'b1;
        m_rem = 0;
        m_cnt = 0;
    endtask

    initial begin
        // rd packs {WB, MEM, EX}; we/load bit 0 is EX.
        tbl[0] = '{4'd3, 4'd4, 1'b1, 1'b1, 12'h000, 3'b000, 1'b0, 2'd0, 2'd0, 32'h11, 32'h22};
        tbl[1] = '{4'd5, 4'd6, 1'b1, 1'b1, 12'h555, 3'b111, 1'b0, 2'd1, 2'd0, 32'hAA, 32'h22};
        tbl[2] = '{4'd5, 4'd6, 1'b1, 1'b1, 12'h555, 3'b110, 1'b0, 2'd2, 2'd0, 32'hBB, 32'h22};
        tbl[3] = '{4'd5, 4'd5, 1'b1, 1'b1, 12'h555, 3'b100, 1'b1, 2'd3, 2'd3, 32'hCC, 32'hCC};
        tbl[4] = '{4'd15, 4'd4, 1'b1, 1'b1, 12'h00F, 3'b001, 1'b0, 2'd0, 2'd0, 32'h11, 32'h22};
        tbl[5] = '{4'd5, 4'd5, 1'b0, 1'b0, 12'h555, 3'b111, 1'b0, 2'd0, 2'd0, 32'h11, 32'h22};
        tbl[6] = '{4'd7, 4'd6, 1'b1, 1'b1, 12'h765, 3'b111, 1'b0, 2'd3, 2'd2, 32'hCC, 32'hBB};
        tbl[7] = '{4'd5, 4'd5, 1'b1, 1'b1, 12'h765, 3'b111, 1'b1, 2'd1, 2'd1, 32'hAA, 32'hAA};

        do_reset("init");

        for (int k = 0; k < 8; k++) begin
            clear_inputs();
            id_rn = tbl[k].rn; id_rm = tbl[k].rm;
            id_rn_used = tbl[k].rn_u; id_rm_used = tbl[k].rm_u;
            src_rd = tbl[k].rd; src_we = tbl[k].we; flush = tbl[k].fl;
            #1;
            check($sformatf("tbl%0d.sel_a", k), sel_a, tbl[k].esa);
            check($sformatf("tbl%0d.sel_b", k), sel_b, tbl[k].esb);
            check($sformatf("tbl%0d.fwd_a", k), fwd_a, tbl[k].efa);
            check($sformatf("tbl%0d.fwd_b", k), fwd_b, tbl[k].efb);
            check($sformatf("tbl%0d.pc_le", k), pc_le, 1);
            check($sformatf("tbl%0d.bubble", k), bubble, 0);
            check($sformatf("tbl%0d.ifid_flush", k), ifid_flush, tbl[k].fl);
            @(negedge clk);
        end

        // Load-use: EX load gives two bubbles, MEM load gives one.
        do_reset("lu");
        id_rm = 4'd2; id_rm_used = 1'b1;
        set_src(0, 4'd2, 1'b1, 1'b1);
        bubbles_seen = 0;
        do_cycle("lu_ex1");
        do_cycle("lu_ex2");
        set_src(0, 4'd0, 1'b0, 1'b0);
        set_src(2, 4'd2, 1'b1, 1'b1);
        do_cycle("lu_ex3");
        check("lu_ex_bubbles", bubbles_seen, 2);
        set_src(2, 4'd0, 1'b0, 1'b0);
        set_src(1, 4'd2, 1'b1, 1'b1);
        bubbles_seen = 0;
        do_cycle("lu_mem1");
        set_src(1, 4'd0, 1'b0, 1'b0);
        set_src(2, 4'd2, 1'b1, 1'b1);
        do_cycle("lu_mem2");
        check("lu_mem_bubbles", bubbles_seen, 1);
        check("lu_stall_cnt", stall_cnt, 3);

        // Memory wait during the STALL cycle freezes without bubbling.
        do_reset("mw");
        id_rm = 4'd2; id_rm_used = 1'b1;
        set_src(0, 4'd2, 1'b1, 1'b1);
        bubbles_seen = 0;
        do_cycle("mw1");
        mem_wait = 1'b1;
        repeat (3) do_cycle("mw_frz");
        mem_wait = 1'b0;
        do_cycle("mw_last");
        set_src(0, 4'd0, 1'b0, 1'b0);
        set_src(2, 4'd2, 1'b1, 1'b1);
        do_cycle("mw_done");
        check("mw_bubbles", bubbles_seen, 2);
        check("mw_stall_cnt", stall_cnt, 2);

        // PC never forwarded; flush honoured only outside a stall.
        do_reset("pf");
        id_rn = 4'd15; id_rn_used = 1'b1;
        set_src(0, 4'd15, 1'b1, 1'b0);
        do_cycle("pc_nofwd");
        flush = 1'b1;
        do_cycle("flush_ok");
        id_rn = 4'd6;
        set_src(0, 4'd6, 1'b1, 1'b1);
        do_cycle("flush_stall1");
        do_cycle("flush_stall2");
        set_src(0, 4'd0, 1'b0, 1'b0);
        flush = 1'b0;
        do_cycle("flush_end");

        // Asynchronous reset in the middle of STALL.
        do_reset("ar");
        id_rn = 4'd9; id_rn_used = 1'b1;
        set_src(0, 4'd9, 1'b1, 1'b1);
        do_cycle("ar_enter");
        #2;
        R = 1'b0;
        #1;
        check("ar_stalling", stalling, 0);
        check("ar_pc_le", pc_le, 1);
        check("ar_bubble", bubble, 0);
        check("ar_stall_cnt", stall_cnt, 0);
        m_rem = 0;
        m_cnt = 0;
        @(negedge clk);
        R = 1'b1;
        set_src(0, 4'd0, 1'b0, 1'b0);
        do_cycle("ar_after");

        // Random traffic against the model.
        do_reset("rnd");
        for (int n = 0; n < 400; n++) begin
            id_rn = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            id_rm = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            id_rn_used = ($urandom_range(0, 3) != 0);
            id_rm_used = ($urandom_range(0, 3) != 0);
            for (int s = 0; s < NSTAGE; s++)
                set_src(s, ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3)),
                        1'($urandom), ($urandom_range(0, 2) == 0));
            src_data = {$urandom, $urandom, $urandom};
            rf_pa = $urandom; rf_pb = $urandom;
            mem_wait = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 3) == 0);
            do_cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
